// File: rtl/step_gen.sv
// Three-axis step pulse generator: loads per-axis velocities from a table,
// then spreads |v| step pulses evenly over PERIOD_CYCLES cycles.
module step_gen #(
  parameter int unsigned PERIOD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        N_reset,
  input  logic        update,
  output logic [1:0]  ra,
  input  logic [31:0] rd,
  input  logic        clr_err,
  output logic [2:0]  step,
  output logic [2:0]  dir,
  output logic        busy,
  output logic        overrun,
  output logic        sat
);

  localparam int unsigned   AW     = $clog2(2 * PERIOD_CYCLES);
  localparam int unsigned   CW     = $clog2(PERIOD_CYCLES);
  localparam logic [AW-1:0] PER_A  = AW'(PERIOD_CYCLES);
  localparam logic [CW-1:0] LAST_C = CW'(PERIOD_CYCLES - 1);
  localparam logic [31:0]   PER_32 = 32'(PERIOD_CYCLES);

  typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, LOAD2, RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] mag_q [3];
  logic [AW-1:0] mag_d [3];
  logic [AW-1:0] acc_q [3];
  logic [AW-1:0] acc_d [3];
  logic [AW-1:0] sum   [3];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dirp_q, dirp_d;
  logic [2:0]    step_q, step_d;
  logic [2:0]    dir_q, dir_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
  logic          sat_q, sat_d;

  logic          rd_neg, rd_big, ovr_set, sat_set;
  logic [31:0]   rd_abs;
  logic [AW-1:0] rd_mag;

  // -2^31 negates to itself, which read as unsigned is exactly 2^31.
  assign rd_neg = rd[31];
  assign rd_abs = rd_neg ? (~rd + 32'd1) : rd;
  assign rd_big = (rd_abs > PER_32);
  assign rd_mag = rd_big ? PER_A : rd_abs[AW-1:0];

  always_comb begin
    unique case (state_q)
      LOAD1:   ra = 2'd1;
      LOAD2:   ra = 2'd2;
      default: ra = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dirp_d  = dirp_q;
    dir_d   = dir_q;
    step_d  = '0;
    sat_set = 1'b0;
    ovr_set = update && (state_q != IDLE);
    for (int unsigned i = 0; i < 3; i++) begin
      mag_d[i] = mag_q[i];
      acc_d[i] = acc_q[i];
      sum[i]   = acc_q[i] + mag_q[i];
    end

    unique case (state_q)
      IDLE: begin
        if (update) state_d = LOAD0;
      end
      LOAD0: begin
        mag_d[0]  = rd_mag;
        dirp_d[0] = rd_neg;
        sat_set   = rd_big;
        state_d   = LOAD1;
      end
      LOAD1: begin
        mag_d[1]  = rd_mag;
        dirp_d[1] = rd_neg;
        sat_set   = rd_big;
        state_d   = LOAD2;
      end
      LOAD2: begin
        mag_d[2] = rd_mag;
        sat_set  = rd_big;
        dir_d    = {rd_neg, dirp_q};
        cnt_d    = '0;
        for (int unsigned i = 0; i < 3; i++) acc_d[i] = '0;
        state_d  = RUN;
      end
      RUN: begin
        if (update) begin
          state_d = LOAD0;
        end else begin
          for (int unsigned i = 0; i < 3; i++) begin
            if (sum[i] >= PER_A) begin
              acc_d[i]  = sum[i] - PER_A;
              step_d[i] = 1'b1;
            end else begin
              acc_d[i] = sum[i];
            end
          end
          if (cnt_q == LAST_C) state_d = IDLE;
          else                 cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE);
    overrun_d = ovr_set ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
    sat_d     = sat_set ? 1'b1 : (clr_err ? 1'b0 : sat_q);
  end

  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dirp_q    <= '0;
      step_q    <= '0;
      dir_q     <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      sat_q     <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
        mag_q[i] <= '0;
        acc_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dirp_q    <= dirp_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      sat_q     <= sat_d;
      for (int unsigned i = 0; i < 3; i++) begin
        mag_q[i] <= mag_d[i];
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign step    = step_q;
  assign dir     = dir_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;
  assign sat     = sat_q;

endmodule

// File: tb/tb_step_gen.sv
// Bench for step_gen: directed intervals with hand-counted steps plus random
// update/clear traffic, all compared every cycle against an interval-level model.
module tb_step_gen;
  localparam int P = 10;

  logic        clk = 1'b0;
  logic        N_reset = 1'b0;
  logic        update = 1'b0;
  logic        clr_err = 1'b0;
  logic [1:0]  ra;
  logic [31:0] rd;
  logic [2:0]  step, dir;
  logic        busy, overrun, sat;
  logic [31:0] vtab [3] = '{32'd0, 32'd0, 32'd0};

  assign rd = (ra == 2'd3) ? 32'd0 : vtab[ra];

  step_gen #(.PERIOD_CYCLES(P)) dut (
    .clk(clk), .N_reset(N_reset), .update(update), .ra(ra), .rd(rd),
    .clr_err(clr_err), .step(step), .dir(dir), .busy(busy),
    .overrun(overrun), .sat(sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ph counts edges since an update was accepted (0 = idle,
  // 1..3 = fetching axis ph-1, 4.. = run cycle k = ph-3).
  int       ph = 0;
  int       mags [3] = '{0, 0, 0};
  bit [2:0] dirn = '0;
  bit [2:0] exp_step = '0;
  bit [2:0] exp_dir = '0;
  bit       exp_ovr = 1'b0;
  bit       exp_sat = 1'b0;

  always @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      ph = 0; exp_step = '0; exp_dir = '0; exp_ovr = 1'b0; exp_sat = 1'b0;
      dirn = '0;
      for (int a = 0; a < 3; a++) mags[a] = 0;
    end else begin
      bit     o_set, s_set;
      int     v, k;
      longint av;
      o_set = (ph != 0) && update;
      s_set = 1'b0;
      exp_step = '0;
      if (ph == 0) begin
        if (update) ph = 1;
      end else if (ph <= 3) begin
        v  = int'(vtab[ph-1]);
        av = (v < 0) ? -longint'(v) : longint'(v);
        if (av > P) begin s_set = 1'b1; mags[ph-1] = P; end
        else mags[ph-1] = int'(av);
        dirn[ph-1] = (v < 0);
        if (ph == 3) exp_dir = dirn;
        ph++;
      end else if (update) begin
        ph = 1;
      end else begin
        k = ph - 3;
        for (int a = 0; a < 3; a++)
          exp_step[a] = ((k * mags[a]) / P) > (((k - 1) * mags[a]) / P);
        ph = (k == P) ? 0 : ph + 1;
      end
      exp_ovr = o_set ? 1'b1 : (clr_err ? 1'b0 : exp_ovr);
      exp_sat = s_set ? 1'b1 : (clr_err ? 1'b0 : exp_sat);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("step", 32'(step), 32'(exp_step));
      check("dir", 32'(dir), 32'(exp_dir));
      check("busy", 32'(busy), 32'(ph != 0));
      check("overrun", 32'(overrun), 32'(exp_ovr));
      check("sat", 32'(sat), 32'(exp_sat));
      check("ra", 32'(ra), (ph == 2) ? 32'd1 : (ph == 3) ? 32'd2 : 32'd0);
    end
  end

  // Step pulses are tallied at the rising edge, i.e. the value shown in the preceding cycle.
  int scnt [3] = '{0, 0, 0};
  always @(posedge clk) begin
    for (int a = 0; a < 3; a++) scnt[a] += int'(step[a]);
  end

  task automatic clear_counts();
    for (int a = 0; a < 3; a++) scnt[a] = 0;
  endtask

  task automatic run_interval(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
    @(negedge clk);
    vtab[0] = v0; vtab[1] = v1; vtab[2] = v2;
    update = 1'b1;
    clear_counts();
    @(negedge clk);
    update = 1'b0;
    check("lit_ra0", 32'(ra), 32'd0);
    @(negedge clk);
    check("lit_ra1", 32'(ra), 32'd1);
    @(negedge clk);
    check("lit_ra2", 32'(ra), 32'd2);
    repeat (P) @(negedge clk);
    check("lit_busy_last", 32'(busy), 32'd1);
    @(negedge clk);
    check("lit_busy_done", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    N_reset = 1'b1;
    repeat (50) @(negedge clk);
    check("lit_idle_busy", 32'(busy), 32'd0);
    check("lit_idle_step", 32'(step), 32'd0);
    check("lit_idle_dir", 32'(dir), 32'd0);

    run_interval(32'd10, -32'sd5, 32'd0);
    check("lit_s2_ax0", scnt[0], 32'd10);
    check("lit_s2_ax1", scnt[1], 32'd5);
    check("lit_s2_ax2", scnt[2], 32'd0);
    check("lit_s2_dir", 32'(dir), 32'b010);
    check("lit_s2_sat", 32'(sat), 32'd0);

    run_interval(32'd25, 32'd0, 32'd0);
    check("lit_s3_ax0", scnt[0], 32'd10);
    check("lit_s3_sat", 32'(sat), 32'd1);
    pulse_clr();
    check("lit_s3_clr", 32'(sat), 32'd0);

    run_interval(32'h8000_0000, 32'd0, 32'd0);
    check("lit_s4_ax0", scnt[0], 32'd10);
    check("lit_s4_dir", 32'(dir), 32'b001);
    check("lit_s4_sat", 32'(sat), 32'd1);
    pulse_clr();

    // 5 run cycles of +10, then reload with +3: 5 old + 3 new steps.
    @(negedge clk);
    vtab[0] = 32'd10; vtab[1] = 32'd0; vtab[2] = 32'd0;
    update = 1'b1;
    clear_counts();
    @(negedge clk); update = 1'b0;
    repeat (8) @(negedge clk);
    vtab[0] = 32'd3;
    update = 1'b1;
    @(negedge clk); update = 1'b0;
    check("lit_s5_ovr", 32'(overrun), 32'd1);
    repeat (13) @(negedge clk);
    check("lit_s5_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("lit_s5_ax0", scnt[0], 32'd8);
    pulse_clr();
    check("lit_s5_clr", 32'(overrun), 32'd0);

    // Reset in the middle of a run, with an update attempted during reset.
    @(negedge clk);
    vtab[0] = 32'd7; vtab[1] = -32'sd3; vtab[2] = 32'd2;
    update = 1'b1;
    @(negedge clk); update = 1'b0;
    repeat (6) @(negedge clk);
    #2 N_reset = 1'b0;
    #1;
    check("lit_rst_step", 32'(step), 32'd0);
    check("lit_rst_dir", 32'(dir), 32'd0);
    check("lit_rst_busy", 32'(busy), 32'd0);
    check("lit_rst_ra", 32'(ra), 32'd0);
    @(negedge clk); update = 1'b1;
    @(negedge clk); update = 1'b0;
    @(negedge clk); N_reset = 1'b1;
    @(negedge clk);
    check("lit_rst_idle", 32'(busy), 32'd0);
    run_interval(32'd7, -32'sd3, 32'd2);
    check("lit_s6_ax0", scnt[0], 32'd7);
    check("lit_s6_ax1", scnt[1], 32'd3);
    check("lit_s6_ax2", scnt[2], 32'd2);
    check("lit_s6_dir", 32'(dir), 32'b010);

    // Random traffic: updates land in idle, load and run phases alike.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      update  = ($urandom_range(0, 24) == 0);
      clr_err = ($urandom_range(0, 19) == 0);
      if (update) begin
        for (int a = 0; a < 3; a++) begin
          if ($urandom_range(0, 9) == 0) vtab[a] = $urandom;
          else vtab[a] = 32'($urandom_range(0, 28)) - 32'd14;
        end
      end
    end
    @(negedge clk);
    update = 1'b0; clr_err = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/step_gen.md
STEP_GEN -- requirements
Module: step_gen

Interface
REQ-001 SHALL have parameter PERIOD_CYCLES, default 1000: RUN cycles per update interval (>=2).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port N_reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port update  input  1  interval-start strobe, same pulse that drives the velocity table's update.
REQ-005 SHALL have port ra  output  2  velocity-table read address (axis 0..2).
REQ-006 SHALL have port rd  input  32  velocity-table read data, signed two's complement steps per interval.
REQ-007 SHALL have port clr_err  input  1  clears sticky flags.
REQ-008 SHALL have port step  output  3  per-axis step pulse, one clk wide.
REQ-009 SHALL have port dir  output  3  per-axis direction, 1 = negative velocity.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port overrun  output  1  sticky: update arrived while busy.
REQ-012 SHALL have port sat  output  1  sticky: a loaded |velocity| exceeded PERIOD_CYCLES.

Function
REQ-013 SHALL implement states IDLE, LOAD0, LOAD1, LOAD2, RUN.
REQ-014 SHALL drive ra = 0 in IDLE/LOAD0/RUN, 1 in LOAD1, 2 in LOAD2, combinationally from state.
REQ-015 SHALL, in IDLE with update=1, go to LOAD0 on that edge; table data becomes valid on the same edge.
REQ-016 SHALL capture rd as axis 0 on the LOAD0->LOAD1 edge, axis 1 on LOAD1->LOAD2, axis 2 on LOAD2->RUN; first RUN cycle is 4 clocks after update sampled.
REQ-017 SHALL per axis store mag = min(|rd|, PERIOD_CYCLES) and dir bit = rd[31]; rd = -2^31 treated as magnitude 2^31 (saturates).
REQ-018 SHALL set sat on capture when |rd| > PERIOD_CYCLES.
REQ-019 SHALL update dir outputs for all axes simultaneously on the LOAD2->RUN edge and hold them until the next such edge.
REQ-020 SHALL clear all three accumulators and the run counter on the LOAD2->RUN edge.
REQ-021 SHALL each RUN cycle per axis compute s = acc + mag; if s >= PERIOD_CYCLES then acc <= s - PERIOD_CYCLES and step[axis] high that cycle (registered, visible next cycle), else acc <= s.
REQ-022 SHALL remain in RUN exactly PERIOD_CYCLES cycles, then return to IDLE; an axis with mag m emits exactly m steps per interval, evenly spaced.
REQ-023 SHALL size accumulators to hold 2*PERIOD_CYCLES-1 without overflow.
REQ-024 SHALL, on update during RUN, set overrun, abandon remaining steps, and go to LOAD0 (new data wins).
REQ-025 SHALL, on update during LOAD0..LOAD2, set overrun and otherwise ignore it.
REQ-026 SHALL clear overrun and sat when clr_err=1 unless a new set event occurs that same cycle (set wins).
REQ-027 SHALL produce no step pulses outside RUN except the registered pulse from the final RUN cycle.

Reset
REQ-028 SHALL on N_reset low asynchronously force IDLE, step=0, dir=0, busy=0, overrun=0, sat=0, accumulators/magnitudes/counter=0, ra=0.
REQ-029 SHALL on reset mid-RUN cease stepping immediately and ignore update until N_reset is released.

Verification (PERIOD_CYCLES=10)
REQ-030 Reset released, no update -> busy=0, step=000, dir=000 for 50 clocks.
REQ-031 Velocities {+10, -5, 0}, one update -> ra sequence 0,1,2; axis0 10 pulses, axis1 5 pulses every other cycle with dir[1]=1, axis2 none; busy low after 13 clocks.
REQ-032 Velocity axis0 = +25 -> 10 steps, sat=1; clr_err pulse -> sat=0.
REQ-033 Velocity axis0 = -2^31 -> dir[0]=1, 10 steps, sat=1.
REQ-034 Second update 5 cycles into RUN with axis0 = +3 -> overrun=1, reload, exactly 3 further axis0 steps in new interval.
REQ-035 N_reset asserted mid-RUN then released -> all outputs at reset values, next update produces a full, correct interval.
